// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution: two line buffers, 3x3 window, runtime signed kernel, 2-stage MAC pipeline.
// Optional CONV_SAT_EN clamps the signed sum to [0, 2^OUT_W-1]; without it the sum is truncated.

module conv3x3_stream #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 25,
  parameter int PIX_W = 4,
  parameter int KW    = 5,
  parameter int OUT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     coef_we,
  input  logic [3:0]               coef_idx,
  input  logic signed [KW-1:0]     coef_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PIX_W-1:0]         in_pix,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_pix,
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int RW    = $clog2(IMG_H);
  localparam int CW    = $clog2(IMG_W);
  localparam int PRD_W = PIX_W + 1 + KW;
  localparam int ACC_W = PIX_W + KW + 4;

  logic                     rdy_q;
  logic                     stall;
  logic                     accept;
  logic                     launch;
  logic                     last_pix;
  logic                     last_out;
  logic [RW-1:0]            row;
  logic [CW-1:0]            col;
  logic                     tail;
  logic                     nxt;
  logic [PIX_W-1:0]         lb1 [IMG_W];
  logic [PIX_W-1:0]         lb2 [IMG_W];
  logic [PIX_W-1:0]         win [9];
  logic signed [KW-1:0]     kern [9];
  logic                     v0;
  logic                     v1;
  logic [RW-1:0]            row0;
  logic [RW-1:0]            row1;
  logic [CW-1:0]            col0;
  logic [CW-1:0]            col1;
  logic signed [PRD_W-1:0]  prod [9];
  logic signed [ACC_W-1:0]  sum;
  logic [OUT_W-1:0]         res;

  assign stall    = out_valid && !out_ready;
  assign in_ready = rdy_q && !stall;
  assign accept   = in_valid && in_ready;
  assign launch   = accept && (row >= RW'(2)) && (col >= CW'(2));
  assign last_pix = (row == RW'(IMG_H-1)) && (col == CW'(IMG_W-1));
  assign last_out = out_valid && out_ready &&
                    (out_row == RW'(IMG_H-2)) && (out_col == CW'(IMG_W-2));

  // tail: last pixel of the frame taken, outputs still draining; nxt: next frame already started
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q      <= 1'b0;
      row        <= '0;
      col        <= '0;
      busy       <= 1'b0;
      tail       <= 1'b0;
      nxt        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      rdy_q      <= 1'b1;
      frame_done <= last_out;
      if (accept) begin
        if (col == CW'(IMG_W-1)) begin
          col <= '0;
          row <= (row == RW'(IMG_H-1)) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (last_out) begin
        busy <= nxt || accept;
        nxt  <= 1'b0;
        tail <= 1'b0;
      end else begin
        if (accept)             busy <= 1'b1;
        if (accept && tail)     nxt  <= 1'b1;
        if (accept && last_pix) tail <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col] <= lb1[col];
      lb1[col] <= in_pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        win[i]  <= '0;
        kern[i] <= (i == 4) ? KW'(8) : {KW{1'b1}};
      end
    end else begin
      if (accept) begin
        win[0] <= win[1];
        win[1] <= win[2];
        win[2] <= lb2[col];
        win[3] <= win[4];
        win[4] <= win[5];
        win[5] <= lb1[col];
        win[6] <= win[7];
        win[7] <= win[8];
        win[8] <= in_pix;
      end
      if (coef_we && !busy) begin
        for (int i = 0; i < 9; i++) begin
          if (coef_idx == 4'(i)) kern[i] <= coef_data;
        end
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++) sum = sum + ACC_W'(prod[i]);
  end

`ifdef CONV_SAT_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << OUT_W) - 1);

  always_comb begin
    res = sum[OUT_W-1:0];
    if (sum[ACC_W-1])       res = '0;
    else if (sum > OUT_MAX) res = '1;
  end
`else
  always_comb begin
    res = sum[OUT_W-1:0];
  end
`endif

  // Whole pipeline advances together; a stalled output freezes every stage behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      row0      <= '0;
      col0      <= '0;
      row1      <= '0;
      col1      <= '0;
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_row   <= '0;
      out_col   <= '0;
      for (int i = 0; i < 9; i++) prod[i] <= '0;
    end else if (!stall) begin
      v0 <= launch;
      if (launch) begin
        row0 <= row - RW'(1);
        col0 <= col - CW'(1);
      end
      v1   <= v0;
      row1 <= row0;
      col1 <= col0;
      for (int i = 0; i < 9; i++) begin
        prod[i] <= PRD_W'($signed({1'b0, win[i]})) * PRD_W'(kern[i]);
      end
      out_valid <= v1;
      if (v1) begin
        out_pix <= res;
        out_row <= row1;
        out_col <= col1;
      end
    end
  end

endmodule
